// File: rtl/fan_pkg.sv
// Shared types and constants for the fan tach monitor.
//   fan_state_t   : per-fan lifecycle state (encoding is visible on o_fan_state)
//   FAN_DUTY_FULL : fail-safe duty driven while a fault is latched
//   THR_SHIFT     : right shift turning MAX_CNT*duty into the 50% threshold
package fan_pkg;

   typedef enum logic [1:0] {
      ABSENT = 2'd0,
      SPINUP = 2'd1,
      RUN    = 2'd2,
      FAULT  = 2'd3
   } fan_state_t;

   localparam logic [7:0] FAN_DUTY_FULL = 8'd255;

   // >>8 scales by duty/256, one more bit halves it: thr is half the expected count.
   localparam int THR_SHIFT = 9;

endpackage

// File: rtl/fan_rotor_check.sv
// Per-rotor speed check: threshold from duty, saturating bad-sample counter,
// sticky fail flag.
//   clk, rst  : clock, async active-high reset
//   cnt       : tach count for the last second
//   duty      : commanded duty, used to scale the threshold
//   smp       : accepted sample this cycle (not dropped by clear/removal)
//   chk       : this sample is to be judged (RUN, checked duty, rotor enabled)
//   clr       : clear counter and flag
//   trip      : this sample latches the fault (combinational, for the FSM)
//   fail_nxt  : next value of the fail flag (for the registered fan fault OR)
//   fail      : sticky fail flag
module fan_rotor_check
   import fan_pkg::*;
#(
   parameter logic [10:0] MAX_CNT      = 11'h3B6,
   parameter int          FAIL_SAMPLES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] cnt,
   input  logic [7:0]  duty,
   input  logic        smp,
   input  logic        chk,
   input  logic        clr,
   output logic        trip,
   output logic        fail_nxt,
   output logic        fail
);

   logic [18:0] prod;
   logic        bad;
   logic [2:0]  bad_cnt;
   logic [2:0]  bad_inc;

   assign prod = 19'(MAX_CNT) * 19'(duty);
   // Strictly below threshold is bad; a count of zero is always bad here.
   assign bad  = chk && (19'(cnt) < (prod >> THR_SHIFT));

   assign bad_inc  = (bad_cnt == 3'd7) ? 3'd7 : bad_cnt + 3'd1;
   assign trip     = smp & bad & (bad_inc >= 3'(FAIL_SAMPLES));
   assign fail_nxt = ~clr & (fail | trip);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bad_cnt <= 3'd0;
         fail    <= 1'b0;
      end else begin
         fail <= fail_nxt;
         if (clr)
            bad_cnt <= 3'd0;
         else if (smp)
            // Good or unchecked samples break the run of bad ones.
            bad_cnt <= bad ? bad_inc : 3'd0;
      end
   end

endmodule

// File: rtl/fan_tach_monitor.sv
// Fan slot monitor: judges per-second tach counts against commanded duty,
// tracks presence/spin-up/run/fault, and forces full duty on fault.
//   i_clk, i_rst        : clock, async active-high reset
//   i_sample_vld        : one-cycle pulse qualifying the tach counts
//   i_tach0/1_cnt       : per-rotor counts for the last second
//   i_dual_rotor        : rotor 1 is checked when set
//   i_pwm_duty          : commanded duty
//   i_fan_present_n     : low when the fan is installed
//   i_clr_fault         : one-cycle pulse clearing a latched fault
//   o_pwm_duty          : duty to the PWM stage (255 while in FAULT)
//   o_rotor0/1_fail     : sticky rotor faults
//   o_fan_fault         : OR of the rotor faults
//   o_fan_state         : ABSENT/SPINUP/RUN/FAULT
module fan_tach_monitor
   import fan_pkg::*;
#(
   parameter logic [10:0] MAX_CNT        = 11'h3B6,
   parameter logic [7:0]  DUTY_CHECK_MIN = 8'd26,
   parameter int          FAIL_SAMPLES   = 3,
   parameter int          SPINUP_SAMPLES = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_sample_vld,
   input  logic [10:0] i_tach0_cnt,
   input  logic [10:0] i_tach1_cnt,
   input  logic        i_dual_rotor,
   input  logic [7:0]  i_pwm_duty,
   input  logic        i_fan_present_n,
   input  logic        i_clr_fault,
   output logic [7:0]  o_pwm_duty,
   output logic        o_rotor0_fail,
   output logic        o_rotor1_fail,
   output logic        o_fan_fault,
   output logic [1:0]  o_fan_state
);

   fan_state_t       state;
   logic [3:0]       spin_cnt;
   logic [7:0]       prev_duty;
   logic             smp_ok;
   logic             clr;
   logic             duty_chk;
   logic             rising;
   logic             run_chk;
   logic [1:0][10:0] tach_cnt;
   logic [1:0]       chk;
   logic [1:0]       trip;
   logic [1:0]       fail_nxt;
   logic [1:0]       fail;

   // Removal and clear both swallow a coincident sample.
   assign smp_ok   = i_sample_vld & ~i_fan_present_n & ~i_clr_fault;
   assign clr      = i_fan_present_n | i_clr_fault | (state == ABSENT);
   assign duty_chk = (i_pwm_duty >= DUTY_CHECK_MIN);
   // Duty crossing up into the checked range: the rotor needs time to catch up.
   assign rising   = duty_chk & (prev_duty < DUTY_CHECK_MIN);
   assign run_chk  = (state == RUN) & duty_chk & ~rising;

   assign tach_cnt = {i_tach1_cnt, i_tach0_cnt};
   assign chk      = {run_chk & i_dual_rotor, run_chk};

   for (genvar r = 0; r < 2; r++) begin : g_rot
      fan_rotor_check #(
         .MAX_CNT      (MAX_CNT),
         .FAIL_SAMPLES (FAIL_SAMPLES)
      ) u_chk (
         .clk      (i_clk),
         .rst      (i_rst),
         .cnt      (tach_cnt[r]),
         .duty     (i_pwm_duty),
         .smp      (smp_ok),
         .chk      (chk[r]),
         .clr      (clr),
         .trip     (trip[r]),
         .fail_nxt (fail_nxt[r]),
         .fail     (fail[r])
      );
   end

   assign o_rotor0_fail = fail[0];
   assign o_rotor1_fail = fail[1];
   assign o_fan_state   = state;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= ABSENT;
         spin_cnt    <= 4'd0;
         prev_duty   <= 8'd0;
         o_pwm_duty  <= 8'd0;
         o_fan_fault <= 1'b0;
      end else begin
         o_fan_fault <= |fail_nxt;
         o_pwm_duty  <= (state == FAULT) ? FAN_DUTY_FULL : i_pwm_duty;
         if (smp_ok)
            prev_duty <= i_pwm_duty;

         if (i_fan_present_n) begin
            state    <= ABSENT;
            spin_cnt <= 4'd0;
         end else if (i_clr_fault) begin
            if (state == FAULT || state == ABSENT) begin
               state    <= SPINUP;
               spin_cnt <= 4'd0;
            end
         end else begin
            case (state)
               ABSENT: begin
                  state    <= SPINUP;
                  spin_cnt <= 4'd0;
               end
               SPINUP: begin
                  if (smp_ok) begin
                     if (spin_cnt == 4'(SPINUP_SAMPLES - 1)) begin
                        state    <= RUN;
                        spin_cnt <= 4'd0;
                     end else begin
                        spin_cnt <= spin_cnt + 4'd1;
                     end
                  end
               end
               RUN: begin
                  if (smp_ok) begin
                     if (rising) begin
                        state    <= SPINUP;
                        spin_cnt <= 4'd0;
                     end else if (|trip) begin
                        state <= FAULT;
                     end
                  end
               end
               default: ; // FAULT holds until cleared or removed
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fan_tach_monitor.sv
module tb_fan_tach_monitor;
   import fan_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        sample_vld;
   logic [10:0] tach0_cnt;
   logic [10:0] tach1_cnt;
   logic        dual_rotor;
   logic [7:0]  pwm_duty_in;
   logic        fan_present_n;
   logic        clr_fault;
   logic [7:0]  pwm_duty_out;
   logic        rotor0_fail;
   logic        rotor1_fail;
   logic        fan_fault;
   logic [1:0]  fan_state;

   typedef struct {
      string       tag;
      fan_state_t  st;
      logic        f0;
      logic        f1;
      logic        ff;
      logic [7:0]  duty;
   } exp_t;

   exp_t       sb[$];
   fan_state_t last_st = ABSENT;
   int         vectors = 0;
   int         miscompares = 0;

   always #5 clk = ~clk;

   fan_tach_monitor dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_sample_vld    (sample_vld),
      .i_tach0_cnt     (tach0_cnt),
      .i_tach1_cnt     (tach1_cnt),
      .i_dual_rotor    (dual_rotor),
      .i_pwm_duty      (pwm_duty_in),
      .i_fan_present_n (fan_present_n),
      .i_clr_fault     (clr_fault),
      .o_pwm_duty      (pwm_duty_out),
      .o_rotor0_fail   (rotor0_fail),
      .o_rotor1_fail   (rotor1_fail),
      .o_fan_fault     (fan_fault),
      .o_fan_state     (fan_state)
   );

   task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock of stimulus; expectation is queued at drive time and retired
   // after the edge. Expected duty: 255 if the fan was in FAULT before the
   // edge, otherwise the duty driven this cycle.
   task automatic step(input string tag, input logic vld, input logic [10:0] c0, input logic [10:0] c1,
                       input logic [7:0] duty, input logic clr, input logic pn, input logic dual,
                       input fan_state_t st, input logic f0, input logic f1);
      exp_t e;
      exp_t g;
      @(negedge clk);
      sample_vld    = vld;
      tach0_cnt     = c0;
      tach1_cnt     = c1;
      pwm_duty_in   = duty;
      clr_fault     = clr;
      fan_present_n = pn;
      dual_rotor    = dual;
      e.tag  = tag;
      e.st   = st;
      e.f0   = f0;
      e.f1   = f1;
      e.ff   = f0 | f1;
      e.duty = (last_st == FAULT) ? FAN_DUTY_FULL : duty;
      last_st = st;
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      check({g.tag, ".state"}, 11'(fan_state),    11'(g.st));
      check({g.tag, ".r0"},    11'(rotor0_fail),  11'(g.f0));
      check({g.tag, ".r1"},    11'(rotor1_fail),  11'(g.f1));
      check({g.tag, ".fault"}, 11'(fan_fault),    11'(g.ff));
      check({g.tag, ".duty"},  11'(pwm_duty_out), 11'(g.duty));
   endtask

   initial begin
      logic [10:0] trans [5];
      trans = '{11'd100, 11'd100, 11'd300, 11'd100, 11'd100};

      rst = 1'b1; sample_vld = 1'b0; tach0_cnt = '0; tach1_cnt = '0; dual_rotor = 1'b1;
      pwm_duty_in = 8'd0; fan_present_n = 1'b1; clr_fault = 1'b0;
      #3;
      check("rst.state", 11'(fan_state), 11'(ABSENT));
      check("rst.r0", 11'(rotor0_fail), 11'd0);
      check("rst.r1", 11'(rotor1_fail), 11'd0);
      check("rst.fault", 11'(fan_fault), 11'd0);
      check("rst.duty", 11'(pwm_duty_out), 11'd0);
      @(negedge clk);
      rst = 1'b0;

      // Absent still passes duty through; insertion enters spin-up.
      step("absent",  0, 0, 0, 255, 0, 1, 1, ABSENT, 0, 0);
      step("present", 0, 0, 0, 255, 0, 0, 1, SPINUP, 0, 0);

      // Normal run at full duty (thr 473).
      for (int i = 0; i < 4; i++)
         step("spin255", 1, 900, 850, 255, 0, 0, 1, (i == 3) ? RUN : SPINUP, 0, 0);
      step("run",     1, 900, 850, 255, 0, 0, 1, RUN, 0, 0);
      step("run",     1, 900, 850, 255, 0, 0, 1, RUN, 0, 0);
      // Count equal to threshold is not bad.
      for (int i = 0; i < 3; i++)
         step("at_thr", 1, 473, 473, 255, 0, 0, 1, RUN, 0, 0);
      // Single rotor: dead rotor 1 is ignored.
      for (int i = 0; i < 3; i++)
         step("single", 1, 900, 0, 255, 0, 0, 0, RUN, 0, 0);

      // Stall at duty 128 (thr 237): third bad sample latches.
      step("stall1", 1, 100, 300, 128, 0, 0, 1, RUN,   0, 0);
      step("stall2", 1, 100, 300, 128, 0, 0, 1, RUN,   0, 0);
      step("stall3", 1, 100, 300, 128, 0, 0, 1, FAULT, 1, 0);
      step("fdty",   0, 100, 300, 128, 0, 0, 1, FAULT, 1, 0);

      // Clear with a coincident sample: sample dropped, back to spin-up.
      step("clr_smp", 1, 100, 300, 128, 1, 0, 1, SPINUP, 0, 0);
      for (int i = 0; i < 4; i++)
         step("spin128", 1, 300, 300, 128, 0, 0, 1, (i == 3) ? RUN : SPINUP, 0, 0);

      // Transient on rotor 1: good sample resets the run of bad ones.
      for (int i = 0; i < 5; i++)
         step("trans", 1, 300, trans[i], 128, 0, 0, 1, RUN, 0, 0);
      step("trip1", 1, 300, 100, 128, 0, 0, 1, FAULT, 0, 1);
      step("clr",   0, 300, 300, 128, 1, 0, 1, SPINUP, 0, 0);
      for (int i = 0; i < 4; i++)
         step("spin128b", 1, 300, 300, 128, 0, 0, 1, (i == 3) ? RUN : SPINUP, 0, 0);

      // Low duty is not checked; crossing up to 200 re-enters spin-up.
      for (int i = 0; i < 3; i++)
         step("lowduty", 1, 0, 0, 20, 0, 0, 1, RUN, 0, 0);
      step("rise", 1, 900, 900, 200, 0, 0, 1, SPINUP, 0, 0);
      for (int i = 0; i < 4; i++)
         step("spin200", 1, 900, 900, 200, 0, 0, 1, (i == 3) ? RUN : SPINUP, 0, 0);

      // Removal mid-run with two bad samples pending; those must not carry over.
      step("bad_a", 1, 0, 900, 200, 0, 0, 1, RUN, 0, 0);
      step("bad_b", 1, 0, 900, 200, 0, 0, 1, RUN, 0, 0);
      step("remove",   0, 0, 900, 200, 0, 1, 1, ABSENT, 0, 0);
      step("reinsert", 0, 0, 900, 200, 0, 0, 1, SPINUP, 0, 0);
      for (int i = 0; i < 4; i++)
         step("spin200b", 1, 900, 900, 200, 0, 0, 1, (i == 3) ? RUN : SPINUP, 0, 0);
      step("bad_c", 1, 0, 900, 200, 0, 0, 1, RUN,   0, 0);
      step("bad_d", 1, 0, 900, 200, 0, 0, 1, RUN,   0, 0);
      step("bad_e", 1, 0, 900, 200, 0, 0, 1, FAULT, 1, 0);
      step("hold",  0, 0, 900, 200, 0, 0, 1, FAULT, 1, 0);

      // Asynchronous reset while in FAULT, checked before the next clock edge.
      @(negedge clk);
      sample_vld = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("arst.state", 11'(fan_state), 11'(ABSENT));
      check("arst.r0", 11'(rotor0_fail), 11'd0);
      check("arst.r1", 11'(rotor1_fail), 11'd0);
      check("arst.fault", 11'(fan_fault), 11'd0);
      check("arst.duty", 11'(pwm_duty_out), 11'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
